i2s_audio_tx: RTL

- Serializes a stereo pair of 16-bit signed PCM samples to the on-board I2S DAC (CS4344-class).
- Consumes the square-wave samples built from the volume amplitude words (volume_max / volume_min) by the note generator.
- Generates MCLK, LRCK and SCK from the 100 MHz system clock.
- Issues a one-cycle sample request per frame so the upstream generator knows when to present the next pair.

---
 rtl/audio_pkg.sv | 30 +++
 rtl/i2s_clkgen.sv | 52 +++++
 rtl/i2s_audio_tx.sv | 81 ++++++++
 3 files changed

// File: rtl/audio_pkg.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// audio_pkg
//   Shared constants and types for the I2S audio transmit path.
//   - AUDIO_W / FRAME_CNT_W : channel slot width and frame divider width
//   - *_BIT                 : divider taps driving the DAC clocks
//   - FRAME_LAST            : last count of a frame (capture point)
//   - audio_sample_t        : signed PCM sample as produced upstream
// ---------------------------------------------------------------------------
package audio_pkg;

    localparam int AUDIO_W     = 16;
    localparam int FRAME_CNT_W = 9;

    // Divider taps: mclk = clk/4, sck = clk/16, lrck = clk/512.
    localparam int MCLK_BIT = 1;
    localparam int SCK_BIT  = 3;
    localparam int LRCK_BIT = 8;

    localparam logic [FRAME_CNT_W-1:0] FRAME_LAST = 9'd511;

    typedef logic signed [AUDIO_W-1:0] audio_sample_t;

    // Frame word as shifted out: left slot first, MSB first.
    function automatic logic [2*AUDIO_W-1:0] pack_pair(input audio_sample_t left,
                                                       input audio_sample_t right);
        return {left, right};
    endfunction

endpackage

// File: rtl/i2s_clkgen.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// i2s_clkgen
//   Free-running frame divider for the I2S transmitter. All DAC clocks are
//   taken straight from counter flops, so they are glitch-free.
//   Ports:
//     clk, rst_n   : system clock, async active-low reset
//     en           : 1 = count, 0 = hold
//     frame_pre    : cnt is one below the last count of the frame
//     frame_last   : cnt is at the last count of the frame
//     sck_fall     : low nibble all ones, i.e. the next edge drops sck
//     mclk/sck/lrck: divider taps
// ---------------------------------------------------------------------------
module i2s_clkgen
    import audio_pkg::*;
#(
    parameter int CNT_W = FRAME_CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic frame_pre,
    output logic frame_last,
    output logic sck_fall,
    output logic mclk,
    output logic sck,
    output logic lrck
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LAST);
    localparam logic [CNT_W-1:0] PRE  = LAST - CNT_W'(1);

    logic [CNT_W-1:0] cnt;

    // Wraps naturally from all-ones to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign frame_pre  = (cnt == PRE);
    assign frame_last = (cnt == LAST);
    assign sck_fall   = &cnt[SCK_BIT:0];

    assign mclk = cnt[MCLK_BIT];
    assign sck  = cnt[SCK_BIT];
    assign lrck = cnt[LRCK_BIT];

endmodule

// File: rtl/i2s_audio_tx.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// i2s_audio_tx
//   Serializes a stereo pair of 16-bit signed samples to an I2S DAC.
//   One frame is 512 clk; the pair is captured on the last cycle of a frame
//   and shifted out MSB first during the next one, with the standard
//   one-bit delay after each lrck transition.
//   Ports:
//     clk, rst_n              : 100 MHz system clock, async active-low reset
//     en                      : 1 = run, 0 = divider and shifter hold
//     mute                    : force the next captured pair to zero
//     audio_left/audio_right  : samples, captured only in the sample_req cycle
//     sample_req              : one clk per frame, inputs taken at its end
//     mclk, lrck, sck, sdin   : DAC interface
// ---------------------------------------------------------------------------
module i2s_audio_tx
    import audio_pkg::*;
#(
    parameter int DATA_W = AUDIO_W,
    parameter int CNT_W  = FRAME_CNT_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          mute,
    input  audio_sample_t audio_left,
    input  audio_sample_t audio_right,
    output logic          sample_req,
    output logic          mclk,
    output logic          lrck,
    output logic          sck,
    output logic          sdin
);

    localparam int SH_W = 2 * DATA_W;

    logic            frame_pre;
    logic            frame_last;
    logic            sck_fall;
    logic [SH_W-1:0] shreg;

    i2s_clkgen #(
        .CNT_W (CNT_W)
    ) u_clkgen (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .frame_pre  (frame_pre),
        .frame_last (frame_last),
        .sck_fall   (sck_fall),
        .mclk       (mclk),
        .sck        (sck),
        .lrck       (lrck)
    );

    // sample_req is computed one cycle early so it leaves a flop: it is high
    // in the cycle where the counter sits on its last value after a counting
    // edge. A pause parked exactly on that value keeps it low.
    //
    // sdin moves on the edge that drops sck, so the DAC sees it stable at the
    // following rising edge. On the frame's last such edge sdin takes the old
    // right LSB while the new pair loads, which yields the one-bit delay.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg      <= '0;
            sdin       <= 1'b0;
            sample_req <= 1'b0;
        end else begin
            sample_req <= en & frame_pre;
            if (en && sck_fall) begin
                sdin <= shreg[SH_W-1];
                if (frame_last) begin
                    shreg <= mute ? '0 : pack_pair(audio_left, audio_right);
                end else begin
                    shreg <= {shreg[SH_W-2:0], 1'b0};
                end
            end
        end
    end

endmodule
